posit_mult_issue: RTL and testbench
===================================

// Module: posit_mult_issue
// PURPOSE
//  Operand sequencer directly upstream of positmult. Buffers incoming posit operand pairs in a small FIFO.
//  Presents each pair to positmult, holds start until done, then returns result+flags on a valid/ready port.
//  Sits between the Pair-HMM operand scheduler and the posit multiplier; keeps operands stable for the multiplier.
// PARAMETERS
//  N         32    posit width (bits)
//  ES        2     posit exponent size (passed through, not used in logic)
//  TAG_W     8     width of opaque tag carried alongside each operand pair
//  DEPTH     4     operand FIFO entries (power of 2, >=2)
//  TIMEOUT   64    max cycles to wait for mult_done before error
// PORTS
//  clk          in   1      clock, rising edge
//  reset_n      in   1      asynchronous active-low reset
//  in_valid     in   1      operand pair valid
//  in_ready     out  1      FIFO can accept (not full)
//  in_a         in   N      posit operand 1
//  in_b         in   N      posit operand 2
//  in_tag       in   TAG_W  tag returned with result
//  mult_in1     out  N      to positmult in1
//  mult_in2     out  N      to positmult in2
//  mult_start   out  1      to positmult start (level)
//  mult_result  in   N      from positmult result
//  mult_inf     in   1      from positmult inf
//  mult_zero    in   1      from positmult zero
//  mult_done    in   1      from positmult done
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  out_result   out  N      product posit
//  out_inf      out  1      product is NaR/inf
//  out_zero     out  1      product is zero
//  out_tag      out  TAG_W  tag of the pair
//  timeout_err  out  1      sticky: multiplier failed to finish within TIMEOUT
// BEHAVIOUR
//  Reset (async, reset_n=0): FIFO empty; state IDLE; all outputs 0 (in_ready=0 while reset asserted, 1 after).
//  Reset mid-operation discards FIFO contents and in-flight product. timeout_err cleared only by reset.
//  Input handshake: push when in_valid&&in_ready. in_ready = !full (registered count). Push on full is ignored.
//  FIFO: wr/rd pointers log2(DEPTH)+1 bits, wrap naturally. Simultaneous push+pop when full is not allowed (in_ready=0).
//  Simultaneous push+pop when non-full: count unchanged.
//  FSM states: IDLE, RUN, HOLD.
//   IDLE: if FIFO non-empty, pop head into operand regs, go RUN next cycle. mult_start=0.
//   RUN: mult_start=1, mult_in1/2 = operand regs (stable the whole state). Cycle counter increments.
//    On mult_done=1: capture result/inf/zero+tag into output regs, out_valid<=1, go HOLD.
//    If counter reaches TIMEOUT with no done: set timeout_err, drop pair, go IDLE.
//   HOLD: mult_start=0 (one-cycle min deassert between operations). Wait for out_valid&&out_ready, then IDLE.
//    Output regs stable while out_valid&&!out_ready.
//  Latency: push to mult_start = 2 cycles when idle; done to out_valid = 1 cycle.
//  Min pair-to-pair spacing = 3 cycles + multiplier latency.
//  mult_done seen in IDLE or HOLD is ignored. mult_done in first RUN cycle is accepted.
//  Operand regs and mult_in1/2 retain last value outside RUN.
//  No arithmetic on posits here; widths pass through unchanged.
// STRUCTURE
//  Shared package posit_pkg: N/ES defaults, issue_state_t enum {IDLE,RUN,HOLD}, operand_pair_t struct {a,b,tag}.
//  One sub-module: posit_pair_fifo (sync FIFO of operand_pair_t, DEPTH, full/empty/count). FSM, timeout counter and
//  output regs live in the top.
// TESTING
//  1. Reset then single push a=b=32'h80003489, tag=8'h11, model done after 3 cycles -> mult_start high 4 cycles,
//     out_valid with out_tag=11 and model result.
//  2. Push DEPTH+1 pairs back-to-back with multiplier stalled -> in_ready=0 after 4 accepted; 5th pair not lost once ready.
//  3. out_ready held 0 for 10 cycles -> out_* stable, mult_start stays 0, FIFO keeps accepting up to full.
//  4. Multiplier never asserts done -> timeout_err=1 at cycle TIMEOUT of RUN; next pair then processed normally.
//  5. Assert reset_n=0 during RUN with 3 pairs queued -> all outputs 0 immediately; after release no stale result.
//  6. Model returns inf=1 for a=32'h80000000, zero=1 for a=0 -> flags passed to out_inf/out_zero with matching tags in order.

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg
//   Types and defaults shared by the posit multiplier issue logic.
//   POSIT_N / POSIT_ES / POSIT_TAG_W : default posit width, exponent size, tag width
//   issue_state_t                    : issue FSM encoding (IDLE, RUN, HOLD)
//   operand_pair_t                   : one operand pair plus its opaque tag
package posit_pkg;

    localparam int POSIT_N     = 32;
    localparam int POSIT_ES    = 2;
    localparam int POSIT_TAG_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [POSIT_N-1:0]     a;
        logic [POSIT_N-1:0]     b;
        logic [POSIT_TAG_W-1:0] tag;
    } operand_pair_t;

endpackage

// File: rtl/posit_pair_fifo.sv
// posit_pair_fifo
//   Synchronous FIFO of operand pairs. Pointers carry one extra wrap bit and
//   wrap naturally; occupancy is kept in its own register so full/empty come
//   straight from a flop compare.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push/wr_data : write request and data (ignored when full)
//   pop/rd_data  : read request (ignored when empty) and head-of-queue data
//   full, empty  : occupancy flags
module posit_pair_fifo
    import posit_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type pair_t = operand_pair_t
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  push,
    input  pair_t wr_data,
    input  logic  pop,
    output pair_t rd_data,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    pair_t         mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        // push and pop together leave the occupancy unchanged
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/posit_mult_issue.sv
// posit_mult_issue
//   Operand sequencer in front of positmult. Queues operand pairs, presents
//   one pair at a time with a level start held until done (or timeout), and
//   returns the product and flags on a valid/ready port.
//   clk, reset_n                : clock, async active-low reset
//   in_valid/in_ready/in_a/in_b/in_tag : operand pair input handshake
//   mult_in1/mult_in2/mult_start       : to the multiplier
//   mult_result/mult_inf/mult_zero/mult_done : from the multiplier
//   out_valid/out_ready/out_result/out_inf/out_zero/out_tag : result port
//   timeout_err                 : sticky, multiplier missed the TIMEOUT window
module posit_mult_issue
    import posit_pkg::*;
#(
    parameter int N       = POSIT_N,
    parameter int ES      = POSIT_ES,
    parameter int TAG_W   = POSIT_TAG_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     mult_in1,
    output logic [N-1:0]     mult_in2,
    output logic             mult_start,
    input  logic [N-1:0]     mult_result,
    input  logic             mult_inf,
    input  logic             mult_zero,
    input  logic             mult_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic             out_inf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Local pair type so the FIFO follows N/TAG_W overrides.
    typedef struct packed {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [TAG_W-1:0] tag;
    } pair_t;

    // ES only matters to the multiplier; checked here so a mismatched
    // instantiation fails at elaboration rather than in silicon.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (ES < 0) || (ES > N - 3) ||
        (TIMEOUT < 1)) begin : g_bad_cfg
        $error("posit_mult_issue: illegal parameter combination");
    end

    issue_state_t     state_q, state_d;
    pair_t            op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_result_q, out_result_d;
    logic             out_inf_q, out_inf_d;
    logic             out_zero_q, out_zero_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             timeout_q, timeout_d;
    logic             alive_q;

    pair_t            fifo_wr, fifo_rd;
    logic             fifo_full, fifo_empty, fifo_pop;

    // alive_q keeps in_ready low while reset is held and for the edge after.
    assign in_ready = alive_q && !fifo_full;
    assign fifo_wr  = '{a: in_a, b: in_b, tag: in_tag};

    posit_pair_fifo #(
        .DEPTH  (DEPTH),
        .pair_t (pair_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_inf_d    = out_inf_q;
        out_zero_d   = out_zero_q;
        out_tag_d    = out_tag_q;
        timeout_d    = timeout_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_rd;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // done is honoured from the very first RUN cycle
                if (mult_done) begin
                    out_valid_d  = 1'b1;
                    out_result_d = mult_result;
                    out_inf_d    = mult_inf;
                    out_zero_d   = mult_zero;
                    out_tag_d    = op_q.tag;
                    state_d      = HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // TIMEOUT RUN cycles without done: the pair is dropped
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // start is low here, giving the multiplier a clean restart
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_inf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
            out_tag_q    <= '0;
            timeout_q    <= 1'b0;
            alive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_inf_q    <= out_inf_d;
            out_zero_q   <= out_zero_d;
            out_tag_q    <= out_tag_d;
            timeout_q    <= timeout_d;
            alive_q      <= 1'b1;
        end
    end

    assign mult_start  = (state_q == RUN);
    assign mult_in1    = op_q.a;
    assign mult_in2    = op_q.b;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_inf     = out_inf_q;
    assign out_zero    = out_zero_q;
    assign out_tag     = out_tag_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_posit_mult_issue.sv
module tb_posit_mult_issue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [7:0]  in_tag = '0;
    logic [31:0] mult_in1, mult_in2, mult_result;
    logic        mult_start, mult_inf, mult_zero, mult_done;
    logic        out_valid, out_inf, out_zero, timeout_err;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [7:0]  out_tag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] r;
        logic        inf;
        logic        zero;
        logic [7:0]  tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // multiplier stub: done after mdl_lat extra start cycles, never if hung
    int   mdl_lat  = 3;
    bit   mdl_hang = 1'b0;
    int   mdl_cnt  = 0;
    int   run_len  = 0;
    int   last_run = 0;

    always #5 clk = ~clk;

    posit_mult_issue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .mult_in1    (mult_in1),
        .mult_in2    (mult_in2),
        .mult_start  (mult_start),
        .mult_result (mult_result),
        .mult_inf    (mult_inf),
        .mult_zero   (mult_zero),
        .mult_done   (mult_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_inf     (out_inf),
        .out_zero    (out_zero),
        .out_tag     (out_tag),
        .timeout_err (timeout_err)
    );

    function automatic logic [33:0] calc(input logic [31:0] a, input logic [31:0] b);
        logic inf, zero;
        logic [31:0] r;
        inf  = (a == 32'h80000000) || (b == 32'h80000000);
        zero = !inf && ((a == 0) || (b == 0));
        r    = inf ? 32'h80000000 : zero ? 32'h0 : (a ^ {b[15:0], b[31:16]}) + 32'h1;
        return {inf, zero, r};
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
        exp_t e;
        logic [33:0] v;
        v = calc(a, b);
        e.inf = v[33]; e.zero = v[32]; e.r = v[31:0]; e.tag = tag;
        return e;
    endfunction

    assign {mult_inf, mult_zero, mult_result} = calc(mult_in1, mult_in2);
    assign mult_done = mult_start && !mdl_hang && (mdl_cnt == mdl_lat);

    always @(posedge clk) mdl_cnt <= mult_start ? mdl_cnt + 1 : 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // start run-length tracker
    always @(negedge clk) begin
        if (mult_start) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    // scoreboard: pop and compare on every accepted result
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("out_result", out_result, mon_e.r);
                chk("out_tag", out_tag, mon_e.tag);
                chk("out_inf", out_inf, mon_e.inf);
                chk("out_zero", out_zero, mon_e.zero);
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                        input bit expect_out);
        int n = 0;
        bit acc = 1'b0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
        else if (expect_out) sb.push_back(mk(a, b, tag));
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_mult_start"}, mult_start, 0);
        chk({pfx, "_mult_in1"}, mult_in1, 0);
        chk({pfx, "_mult_in2"}, mult_in2, 0);
        chk({pfx, "_out_result"}, out_result, 0);
        chk({pfx, "_out_flags"}, {out_inf, out_zero}, 0);
        chk({pfx, "_out_tag"}, out_tag, 0);
        chk({pfx, "_timeout_err"}, timeout_err, 0);
    endtask

    exp_t p0;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_after_rst", in_ready, 1);

        // 1: single pair, done after 3 cycles -> 4 start cycles
        mdl_lat = 3;
        push(32'h80003489, 32'h80003489, 8'h11, 1'b1);
        @(negedge clk);
        chk("lat_start_c1", mult_start, 0);
        @(negedge clk);
        chk("lat_start_c2", mult_start, 1);
        chk("lat_in1", mult_in1, 32'h80003489);
        wait_drain();
        @(negedge clk);
        chk("t1_start_len", last_run, 4);

        // 2+3: result held with out_ready=0, FIFO fills, extra pair waits
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        mdl_lat   = 2;
        push(32'h12345678, 32'h0badcafe, 8'h20, 1'b1);
        p0 = mk(32'h12345678, 32'h0badcafe, 8'h20);
        wait_out_valid();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            push(32'h1000 + i, 32'h2000 + i, 8'h21 + i, 1'b1);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        fork
            push(32'h0000beef, 32'h00c0ffee, 8'h25, 1'b1);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_valid", out_valid, 1);
                    chk("hold_result", out_result, p0.r);
                    chk("hold_tag", out_tag, p0.tag);
                    chk("hold_start", mult_start, 0);
                    chk("hold_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // 4: multiplier hangs -> timeout after TIMEOUT RUN cycles, then recovers
        @(posedge clk);
        #1;
        mdl_hang = 1'b1;
        push(32'h33333333, 32'h44444444, 8'h30, 1'b0);
        chk("to_before", timeout_err, 0);
        for (int n = 0; n < 200 && !timeout_err; n++) @(negedge clk);
        chk("to_err", timeout_err, 1);
        @(negedge clk);
        chk("to_len", last_run, 64);
        @(posedge clk);
        #1;
        mdl_hang = 1'b0;
        mdl_lat  = 1;
        push(32'h55555555, 32'h66666666, 8'h31, 1'b1);
        wait_drain();
        chk("to_sticky", timeout_err, 1);

        // 5: reset during RUN with 3 pairs queued
        @(posedge clk);
        #1;
        mdl_lat = 20;
        for (int i = 0; i < 4; i++)
            push(32'h7000 + i, 32'h7100 + i, 8'h40 + i, 1'b1);
        @(negedge clk);
        chk("r5_running", mult_start, 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("r5");
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("r5_no_stale", out_valid, 0);
        chk("r5_idle_start", mult_start, 0);
        chk("r5_ready", in_ready, 1);

        // 6: inf/zero flags in order
        @(posedge clk);
        #1;
        mdl_lat = 1;
        push(32'h80000000, 32'h12340000, 8'h61, 1'b1);
        push(32'h00000000, 32'h40000000, 8'h62, 1'b1);
        push(32'h40000000, 32'h48000000, 8'h63, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
